// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: hazard-controller state encoding, register
// numbers, decoder opcode/funct constants and the in-flight destination slot.
package mips_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 16;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              load;
  } shadow_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage <-> hazard controller signal bundle; master is the ID stage.
interface pipe_hazard_ctrl_if;
  import mips_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_r1_num;
  logic [REG_AW-1:0] id_r2_num;
  logic              id_uses_r1;
  logic              id_uses_r2;
  logic              id_is_branch;
  logic              id_branch_taken;
  logic              id_jump;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_num;
  logic              id_is_load;
  logic              id_halt;
  logic              ext_stall;
  logic              hazard;
  logic              flush_if;
  logic              fwd_r1_mem;
  logic              fwd_r2_mem;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_r1_num, id_r2_num, id_uses_r1, id_uses_r2, id_is_branch,
           id_branch_taken, id_jump, id_wr_en, id_wr_num, id_is_load, id_halt,
           ext_stall,
    input  hazard, flush_if, fwd_r1_mem, fwd_r2_mem, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_r1_num, id_r2_num, id_uses_r1, id_uses_r2, id_is_branch,
           id_branch_taken, id_jump, id_wr_en, id_wr_num, id_is_load, id_halt,
           ext_stall,
    output hazard, flush_if, fwd_r1_mem, fwd_r2_mem, halted, stall_cnt
  );
endinterface

// File: rtl/hz_shadow_stage.sv
// One in-flight destination slot {valid, rd, load}; writes to $0 are stored
// as invalid so they can never raise a hazard or keep a drain alive.
module hz_shadow_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              bubble,
  input  shadow_t           d,
  input  logic [REG_AW-1:0] r1,
  input  logic [REG_AW-1:0] r2,
  output shadow_t           q,
  output logic              match_r1,
  output logic              match_r2
);

  logic keep;

  assign keep = d.valid & (d.rd != REG_ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (advance) begin
      if (bubble) begin
        q <= '0;
      end else begin
        q.valid <= keep;
        q.rd    <= d.rd;
        q.load  <= d.load & keep;
      end
    end
  end

  assign match_r1 = q.valid & (q.rd == r1) & (r1 != REG_ZERO);
  assign match_r2 = q.valid & (q.rd == r2) & (r2 != REG_ZERO);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: load-use and ID-branch stalls, MEM->ID branch
// forwarding selects, IF flush on taken control flow and syscall halt drain.
module pipe_hazard_ctrl
  import mips_pkg::*;
(
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  hz_state_t        state;
  logic [CNT_W-1:0] cnt;
  shadow_t          ex_d, ex_q, mem_q, wb_q;
  logic             ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic             run, advance, ex_bubble, load_use, branch_haz, hazard_c;
  logic             drain_done, slot_unused;

  assign run     = (state == RUN);
  assign advance = ~bus.ext_stall;

  assign load_use   = bus.id_valid & ex_q.load &
                      ((bus.id_uses_r1 & ex_m1) | (bus.id_uses_r2 & ex_m2));
  // ID compares branch operands, so an ALU result still in EX or a load in MEM is too late
  assign branch_haz = bus.id_valid & bus.id_is_branch &
                      (ex_m1 | ex_m2 | (mem_q.load & (mem_m1 | mem_m2)));
  assign hazard_c   = load_use | branch_haz | ~run;

  // The halting syscall never enters EX, so it cannot hold the drain open
  assign ex_bubble = ~(bus.id_valid & bus.id_wr_en & ~bus.id_halt & ~hazard_c);
  assign ex_d      = '{valid: 1'b1, rd: bus.id_wr_num, load: bus.id_is_load};

  hz_shadow_stage u_ex (
    .clk(clk), .rst(rst), .advance(advance), .bubble(ex_bubble), .d(ex_d),
    .r1(bus.id_r1_num), .r2(bus.id_r2_num), .q(ex_q),
    .match_r1(ex_m1), .match_r2(ex_m2)
  );

  hz_shadow_stage u_mem (
    .clk(clk), .rst(rst), .advance(advance), .bubble(1'b0), .d(ex_q),
    .r1(bus.id_r1_num), .r2(bus.id_r2_num), .q(mem_q),
    .match_r1(mem_m1), .match_r2(mem_m2)
  );

  hz_shadow_stage u_wb (
    .clk(clk), .rst(rst), .advance(advance), .bubble(1'b0), .d(mem_q),
    .r1(bus.id_r1_num), .r2(bus.id_r2_num), .q(wb_q),
    .match_r1(wb_m1), .match_r2(wb_m2)
  );

  // WB is written on negedge, so its slot only matters for draining
  assign slot_unused = ^{ex_q.rd, mem_q.rd, wb_q.rd, wb_q.load, wb_m1, wb_m2};
  assign drain_done  = ~ex_q.valid & ~mem_q.valid & ~wb_q.valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (advance) begin
      if (run && hazard_c && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
      case (state)
        RUN:     if (bus.id_valid && bus.id_halt && !hazard_c) state <= DRAIN;
        DRAIN:   if (drain_done) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.hazard     = hazard_c;
  assign bus.flush_if   = run & bus.id_valid & ~hazard_c &
                          (bus.id_jump | (bus.id_is_branch & bus.id_branch_taken));
  assign bus.fwd_r1_mem = mem_m1 & ~mem_q.load;
  assign bus.fwd_r2_mem = mem_m2 & ~mem_q.load;
  assign bus.halted     = (state == HALTED);
  assign bus.stall_cnt  = cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed instruction sequences; hand-derived expected outputs go through a scoreboard queue.
module tb_pipe_hazard_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic       v;
    logic [4:0] r1, r2;
    logic       u1, u2, br, tk, jmp, we;
    logic [4:0] wn;
    logic       ld, hlt;
  } ins_t;

  typedef struct packed {
    logic        hz, fl, f1, f2, hl;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  pipe_hazard_ctrl_if hif();

  pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(hif.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ins_t i_nop();
    ins_t i = '0;
    return i;
  endfunction
  function automatic ins_t i_alu(input logic [4:0] rd, rs, rt);
    ins_t i = '0;
    i.v = 1; i.r1 = rs; i.r2 = rt; i.u1 = 1; i.u2 = 1; i.we = 1; i.wn = rd;
    return i;
  endfunction
  function automatic ins_t i_lw(input logic [4:0] rd, rs);
    ins_t i = '0;
    i.v = 1; i.r1 = rs; i.u1 = 1; i.we = 1; i.wn = rd; i.ld = 1;
    return i;
  endfunction
  function automatic ins_t i_br(input logic [4:0] rs, rt, input logic taken);
    ins_t i = '0;
    i.v = 1; i.r1 = rs; i.r2 = rt; i.u1 = 1; i.u2 = 1; i.br = 1; i.tk = taken;
    return i;
  endfunction
  function automatic ins_t i_jr(input logic [4:0] rs);
    ins_t i = '0;
    i.v = 1; i.r1 = rs; i.u1 = 1; i.jmp = 1;
    return i;
  endfunction
  function automatic ins_t i_j();
    ins_t i = '0;
    i.v = 1; i.jmp = 1;
    return i;
  endfunction
  function automatic ins_t i_sys();
    ins_t i = '0;
    i.v = 1; i.r1 = 5'd2; i.u1 = 1; i.hlt = 1;
    return i;
  endfunction

  task automatic apply(input ins_t i, input logic xs);
    hif.id_valid        = i.v;
    hif.id_r1_num       = i.r1;
    hif.id_r2_num       = i.r2;
    hif.id_uses_r1      = i.u1;
    hif.id_uses_r2      = i.u2;
    hif.id_is_branch    = i.br;
    hif.id_branch_taken = i.tk;
    hif.id_jump         = i.jmp;
    hif.id_wr_en        = i.we;
    hif.id_wr_num       = i.wn;
    hif.id_is_load      = i.ld;
    hif.id_halt         = i.hlt;
    hif.ext_stall       = xs;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: no expected entry at t=%0t", $time);
    end else begin
      e = sb_q.pop_front();
      check("hazard",     32'(hif.hazard),     32'(e.hz));
      check("flush_if",   32'(hif.flush_if),   32'(e.fl));
      check("fwd_r1_mem", 32'(hif.fwd_r1_mem), 32'(e.f1));
      check("fwd_r2_mem", 32'(hif.fwd_r2_mem), 32'(e.f2));
      check("halted",     32'(hif.halted),     32'(e.hl));
      check("stall_cnt",  32'(hif.stall_cnt),  32'(e.cnt));
    end
  endtask

  // Drive one ID-stage cycle at negedge, then compare mid low-phase
  task automatic step(input ins_t i, input logic xs, input logic hz, fl, f1, f2, hl,
                      input int unsigned cnt);
    @(negedge clk);
    apply(i, xs);
    sb_q.push_back(exp_t'{hz: hz, fl: fl, f1: f1, f2: f2, hl: hl, cnt: 16'(cnt)});
    #1;
    compare_out();
  endtask

  task automatic expect_now(input logic hz, fl, hl, input int unsigned cnt);
    sb_q.push_back(exp_t'{hz: hz, fl: fl, f1: 1'b0, f2: 1'b0, hl: hl, cnt: 16'(cnt)});
    compare_out();
  endtask

  task automatic nops(input int n, input int unsigned cnt);
    for (int k = 0; k < n; k++) step(i_nop(), 0, 0, 0, 0, 0, 0, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(i_nop(), 0);
    #3;
    expect_now(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Load-use: one stall cycle
    step(i_lw(8, 2),      0, 0, 0, 0, 0, 0, 0);
    step(i_alu(9, 8, 8),  0, 1, 0, 0, 0, 0, 0);
    step(i_alu(9, 8, 8),  0, 0, 0, 0, 0, 0, 1);
    nops(3, 1);

    // ALU then beq: one stall, then MEM forward; taken flushes
    step(i_alu(3, 1, 2),  0, 0, 0, 0, 0, 0, 1);
    step(i_br(3, 4, 1),   0, 1, 0, 0, 0, 0, 1);
    step(i_br(3, 4, 1),   0, 0, 1, 1, 0, 0, 2);
    nops(3, 2);
    step(i_alu(4, 1, 2),  0, 0, 0, 0, 0, 0, 2);
    step(i_br(7, 4, 0),   0, 1, 0, 0, 0, 0, 2);
    step(i_br(7, 4, 0),   0, 0, 0, 0, 1, 0, 3);
    nops(3, 3);

    // Load then bne: two stalls, no forward
    step(i_lw(5, 6),      0, 0, 0, 0, 0, 0, 3);
    step(i_br(5, 0, 1),   0, 1, 0, 0, 0, 0, 3);
    step(i_br(5, 0, 1),   0, 1, 0, 0, 0, 0, 4);
    step(i_br(5, 0, 1),   0, 0, 1, 0, 0, 0, 5);
    nops(3, 5);

    // $0 destination is never tracked
    step(i_lw(0, 2),      0, 0, 0, 0, 0, 0, 5);
    step(i_alu(1, 0, 0),  0, 0, 0, 0, 0, 0, 5);
    step(i_br(0, 0, 0),   0, 0, 0, 0, 0, 0, 5);
    nops(3, 5);

    // Jr behind a load stalls before flushing; plain j flushes at once
    step(i_lw(31, 2),     0, 0, 0, 0, 0, 0, 5);
    step(i_jr(31),        0, 1, 0, 0, 0, 0, 5);
    step(i_jr(31),        0, 0, 1, 0, 0, 0, 6);
    step(i_j(),           0, 0, 1, 0, 0, 0, 6);
    nops(3, 6);

    // ext_stall freezes shadows and counter while hazard stays asserted
    step(i_lw(8, 2),      0, 0, 0, 0, 0, 0, 6);
    step(i_alu(9, 8, 8),  1, 1, 0, 0, 0, 0, 6);
    step(i_alu(9, 8, 8),  1, 1, 0, 0, 0, 0, 6);
    step(i_alu(9, 8, 8),  0, 1, 0, 0, 0, 0, 6);
    step(i_alu(9, 8, 8),  0, 0, 0, 0, 0, 0, 7);
    nops(3, 7);

    // Halt with two writes in flight; one ext_stall cycle during drain
    step(i_alu(10, 1, 2), 0, 0, 0, 0, 0, 0, 7);
    step(i_alu(11, 1, 2), 0, 0, 0, 0, 0, 0, 7);
    step(i_sys(),         0, 0, 0, 0, 0, 0, 7);
    step(i_sys(),         0, 1, 0, 0, 0, 0, 7);
    step(i_sys(),         1, 1, 0, 0, 0, 0, 7);
    step(i_sys(),         0, 1, 0, 0, 0, 0, 7);
    step(i_sys(),         0, 1, 0, 0, 0, 0, 7);
    step(i_sys(),         0, 1, 0, 0, 0, 1, 7);
    step(i_j(),           0, 1, 0, 0, 0, 1, 7);
    step(i_nop(),         0, 1, 0, 0, 0, 1, 7);

    // Reset from HALTED
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_now(0, 0, 0, 0);
    @(negedge clk);
    apply(i_nop(), 0);
    rst = 1'b1;

    // Reset asserted asynchronously in the middle of a drain
    step(i_lw(8, 2),      0, 0, 0, 0, 0, 0, 0);
    step(i_alu(9, 8, 8),  0, 1, 0, 0, 0, 0, 0);
    step(i_alu(9, 8, 8),  0, 0, 0, 0, 0, 0, 1);
    step(i_sys(),         0, 0, 0, 0, 0, 0, 1);
    step(i_sys(),         0, 1, 0, 0, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    expect_now(0, 0, 0, 0);
    @(negedge clk);
    apply(i_nop(), 0);
    rst = 1'b1;
    step(i_j(),           0, 0, 1, 0, 0, 0, 0);
    step(i_nop(),         0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline. It shadows destination registers in flight through EX, MEM and WB, and detects load-use and branch-compare hazards against the ID-stage source registers. It drives the ID stage's Hazard/stall input, forwarding selects for the ID branch comparator, the IF flush on taken branches, and the syscall-halt drain sequence.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter
REG_AW, 5, register-number width

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_r1_num  in  REG_AW  ID source register 1 number
id_r2_num  in  REG_AW  ID source register 2 number
id_uses_r1  in  1  instruction reads r1
id_uses_r2  in  1  instruction reads r2
id_is_branch  in  1  Beq or Bne in ID (compares in ID)
id_branch_taken  in  1  ID branch-taken result
id_jump  in  1  J, Jal or Jr in ID
id_wr_en  in  1  instruction writes a register
id_wr_num  in  REG_AW  destination (Jal already resolved to 31)
id_is_load  in  1  MemtoReg instruction
id_halt  in  1  syscall with $v0==10 in ID
ext_stall  in  1  memory wait; freezes the whole pipeline
hazard  out  1  stall PC and IF/ID; ID issues a bubble to EX
flush_if  out  1  squash the IF/ID register
fwd_r1_mem  out  1  ID comparator operand 1 from the MEM ALU result
fwd_r2_mem  out  1  ID comparator operand 2 from the MEM ALU result
halted  out  1  pipeline drained and stopped
stall_cnt  out  CNT_W  count of hazard cycles

Behaviour:
- Shadow registers: ex/mem/wb each hold {valid, rd, load}. At reset all are 0.
- Shadow advance, on posedge when ext_stall=0:
  - wb<=mem; mem<=ex.
  - ex<={id_valid & id_wr_en & ~hazard & state==RUN, id_wr_num, id_is_load}; otherwise ex<= a bubble.
  - When ext_stall=1, all shadow registers, state and stall_cnt hold.
- Write to $0 is never tracked: a shadow entry with rd==0 is treated as invalid.
- match(s,r) = s.valid & s.rd==r & r!=0.
- Load-use: id_valid & ex.load & ((id_uses_r1 & match(ex,r1)) | (id_uses_r2 & match(ex,r2))).
- Branch hazard: id_valid & id_is_branch & (match(ex,r1|r2) | (mem.load & match(mem,r1|r2))).
- fwd_r1_mem = match(mem,r1) & ~mem.load; same for r2. These are independent of hazard.
- WB needs no forward, because the register file writes on negedge.
- hazard is combinational: load_use | branch_haz | state!=RUN.
- flush_if = id_valid & ~hazard & (id_jump | (id_is_branch & id_branch_taken)); forced 0 in DRAIN/HALTED.
- State machine RUN/DRAIN/HALTED, reset RUN:
  - RUN->DRAIN when id_valid & id_halt & ~hazard & ~ext_stall. The halting instruction itself does not enter ex.
  - DRAIN->HALTED when ex, mem and wb are all invalid. Minimum 1 cycle; at most 3 cycles after entry.
  - HALTED is sticky until rst.
- halted=1 only in HALTED.
- stall_cnt increments on every posedge with hazard=1 & ext_stall=0 while state==RUN, and saturates at all-ones.
- Simultaneous load-use and taken branch: hazard wins, flush_if=0; the branch re-evaluates next cycle.
- Reset asserted mid-operation clears all shadows, state and counter immediately. Reset values: hazard=0, flush_if=0, fwd=0, halted=0, stall_cnt=0.

Decomposition:
- Shared package mips_pkg: state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2), REG_ZERO=5'd0, REG_RA=5'd31, opcode/funct constants already used by the decoder.
- One natural sub-module: hz_shadow_stage, a single {valid, rd, load} pipeline slot with hold/bubble/advance controls and a match(r) output, instantiated three times.

Test Plan:
- Load-use: lw $8 then add $9,$8,$8 -> hazard=1 for exactly 1 cycle, ex bubble inserted, stall_cnt=1, no flush.
- ALU-then-beq: add $3 then beq $3,$4 -> 1 hazard cycle, then fwd_r1_mem=1 with hazard=0; taken gives flush_if=1 for 1 cycle.
- Load-then-beq: lw $5 then bne $5,$0 -> hazard=1 for 2 cycles, then no forward (value reaches via WB/negedge write); stall_cnt=2.
- $0 destination: lw $0 then add $1,$0,$0 -> hazard=0, fwd=0 throughout.
- Halt: syscall with id_halt after two in-flight writes -> hazard=1 from next cycle, halted=1 exactly 3 cycles later, stays 1; ext_stall pulse during DRAIN extends by that many cycles.
- Reset mid-DRAIN: drop rst asynchronously -> halted=0, hazard=0, stall_cnt=0 immediately; state RUN after release.
